// File: rtl/popcnt_arbiter.sv
// popcnt_arbiter: round-robin arbiter that lends one 32-bit popcount datapath
// to NREQ requesters, one burst at a time, and returns the per-burst total of
// set bits on a response channel tagged with the owning requester.
// Build option: define POPCNT_SAT_EN to make the accumulator saturate at
// 2^ACC_W-1 instead of wrapping modulo 2^ACC_W.
`timescale 1ns/1ps

module popcnt_arbiter #(
  parameter int NREQ  = 4,
  parameter int ACC_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [32*NREQ-1:0]       req_data,
  input  logic [NREQ-1:0]          req_last,
  output logic [NREQ-1:0]          req_ready,
  output logic                     rsp_valid,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [ACC_W-1:0]         rsp_count,
  input  logic                     rsp_ready,
  output logic                     busy
);

  localparam int ID_W = $clog2(NREQ);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  logic [1:0]       state;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  owner;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next;

  logic [ID_W-1:0]  pick;
  logic             any_valid;

  logic [31:0]      word;
  logic             owner_valid;
  logic             owner_last;

  logic [2:0]       nib_cnt [8];
  logic [3:0]       lvl1    [4];
  logic [4:0]       lvl2    [2];
  logic [5:0]       word_cnt;

  // 4-bit compressor: number of ones in a nibble (0..4).
  function automatic logic [2:0] count4(input logic [3:0] n);
    count4 = {2'b00, n[0]} + {2'b00, n[1]} + {2'b00, n[2]} + {2'b00, n[3]};
  endfunction

  // Route the current owner's word and control bits onto the shared datapath.
  always_comb begin
    word        = req_data[32*int'(owner) +: 32];
    owner_valid = req_valid[owner];
    owner_last  = req_last[owner];
  end

  // Popcount of the owner's word: eight count4 compressors and a 3-level adder tree.
  always_comb begin
    for (int n = 0; n < 8; n++) nib_cnt[n] = count4(word[4*n +: 4]);
    for (int n = 0; n < 4; n++) lvl1[n] = {1'b0, nib_cnt[2*n]} + {1'b0, nib_cnt[2*n+1]};
    for (int n = 0; n < 2; n++) lvl2[n] = {1'b0, lvl1[2*n]} + {1'b0, lvl1[2*n+1]};
    word_cnt = {1'b0, lvl2[0]} + {1'b0, lvl2[1]};
  end

`ifdef POPCNT_SAT_EN
  logic [ACC_W:0] acc_sum;

  // Saturating accumulate: a carry out pins the total at all-ones.
  always_comb begin
    acc_sum  = {1'b0, acc} + (ACC_W+1)'(word_cnt);
    acc_next = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
  end
`else
  // Wrapping accumulate: the total is kept modulo 2^ACC_W.
  always_comb begin
    acc_next = acc + ACC_W'(word_cnt);
  end
`endif

  // Round-robin pick: first requesting index at or above rr_ptr, with wrap.
  // Scanning from the far end lets the nearest candidate overwrite the rest.
  always_comb begin
    // NOTE: every combinational output gets a default before any condition,
    // so no path through the block leaves it unassigned (no latch inferred).
    pick      = '0;
    any_valid = |req_valid;
    for (int k = NREQ-1; k >= 0; k--) begin
      if (req_valid[(int'(rr_ptr) + k) % NREQ]) pick = ID_W'((int'(rr_ptr) + k) % NREQ);
    end
  end

  // Sequencer: arbitrate in IDLE, stream the owner's burst in GRANT, hand back the total in RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      rr_ptr <= '0;
      owner  <= '0;
      acc    <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every register
      // samples the values from before this edge, independent of statement order.
      case (state)
        S_IDLE: begin
          if (any_valid) begin
            owner <= pick;
            acc   <= '0;
            state <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (owner_valid) begin
            acc <= acc_next;
            if (owner_last) state <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rr_ptr <= (owner == ID_W'(NREQ-1)) ? '0 : owner + 1'b1;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Grant decode depends only on registered state and owner.
  always_comb begin
    req_ready = '0;
    if (state == S_GRANT) req_ready[owner] = 1'b1;
  end

  assign rsp_valid = (state == S_RESP);
  assign rsp_id    = owner;
  assign rsp_count = acc;
  assign busy      = (state == S_GRANT) || (state == S_RESP);

endmodule

// File: tb/tb_popcnt_arbiter.sv
// tb_popcnt_arbiter: drives bursts on all requesters and checks grants and
// burst totals against a transaction-level model (queues of words per
// requester, round-robin winner from a pointer, totals via $countones).
// Two instances share the stimulus: ACC_W=16 (no overflow) and ACC_W=6
// (overflow behaviour follows POPCNT_SAT_EN).
`timescale 1ns/1ps

module tb_popcnt_arbiter;

  localparam int N = 4;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [32*N-1:0] req_data;
  logic [N-1:0]    req_last;
  logic            rsp_ready;

  logic [N-1:0]    req_ready;
  logic            rsp_valid;
  logic [1:0]      rsp_id;
  logic [15:0]     rsp_count;
  logic            busy;

  logic [N-1:0]    req_ready_s;
  logic            rsp_valid_s;
  logic [1:0]      rsp_id_s;
  logic [5:0]      rsp_count_s;
  logic            busy_s;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [31:0] bq [N][$];
  bit          pend [N];
  int          ptr;

  popcnt_arbiter #(.NREQ(N), .ACC_W(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_count(rsp_count),
    .rsp_ready(rsp_ready), .busy(busy)
  );

  popcnt_arbiter #(.NREQ(N), .ACC_W(6)) dut_small (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready_s),
    .rsp_valid(rsp_valid_s), .rsp_id(rsp_id_s), .rsp_count(rsp_count_s),
    .rsp_ready(rsp_ready), .busy(busy_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected 6-bit total for a burst sum.
  function automatic int small_total(input int sum);
`ifdef POPCNT_SAT_EN
    return (sum > 63) ? 63 : sum;
`else
    return sum % 64;
`endif
  endfunction

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ready"}, 64'(req_ready), '0);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), '0);
    check({tag, "_rsp_id"}, 64'(rsp_id), '0);
    check({tag, "_rsp_count"}, 64'(rsp_count), '0);
    check({tag, "_busy"}, 64'(busy), '0);
    check({tag, "_rsp_count_small"}, 64'(rsp_count_s), '0);
  endtask

  // Present every pending requester's head word; the owner may insert a gap.
  task automatic apply_inputs(input int own, input bit gap);
    for (int i = 0; i < N; i++) begin
      if (pend[i]) begin
        req_valid[i]         = !(i == own && gap);
        req_data[32*i +: 32] = bq[i][0];
        req_last[i]          = (bq[i].size() == 1);
      end else begin
        req_valid[i]         = 1'b0;
        req_data[32*i +: 32] = '0;
        req_last[i]          = 1'b0;
      end
    end
  endtask

  task automatic rand_burst(input int i);
    int len;
    int r;
    len = $urandom_range(1, 4);
    for (int k = 0; k < len; k++) begin
      r = $urandom_range(0, 7);
      if (r < 3)       bq[i].push_back(32'hFFFF_FFFF);
      else if (r == 3) bq[i].push_back(32'h0);
      else             bq[i].push_back($urandom);
    end
    pend[i] = 1'b1;
  endtask

  task automatic refill();
    bit any;
    any = 1'b0;
    for (int i = 0; i < N; i++) if (!pend[i] && ($urandom_range(0, 1) == 1)) rand_burst(i);
    for (int i = 0; i < N; i++) if (pend[i]) any = 1'b1;
    if (!any) rand_burst($urandom_range(0, N-1));
  endtask

  // One arbitration round, entered #1 into a cycle where the DUT is idle.
  // abort_after >= 0 asserts reset once that many words have been accepted.
  task automatic run_round(input int hold, input int abort_after, input int gap_pct);
    int          w;
    int          sum;
    int          beats;
    bit          gap;
    bit          done;
    logic [N-1:0] oh;
    logic [31:0] saved [$];

    w = -1;
    for (int k = N-1; k >= 0; k--) if (pend[(ptr + k) % N]) w = (ptr + k) % N;
    if (w < 0) return;
    saved = bq[w];
    oh    = '0;
    oh[w] = 1'b1;

    apply_inputs(-1, 1'b0);
    @(negedge clk);
    check("idle_ready", 64'(req_ready), '0);
    check("idle_busy", 64'(busy), '0);
    check("idle_rsp_valid", 64'(rsp_valid), '0);
    @(posedge clk); #1;

    sum   = 0;
    beats = 0;
    done  = 1'b0;
    while (!done) begin
      gap = ($urandom_range(0, 99) < gap_pct);
      apply_inputs(w, gap);
      @(negedge clk);
      check("grant_ready", 64'(req_ready), 64'(oh));
      check("grant_busy", 64'(busy), 64'd1);
      check("grant_rsp_valid", 64'(rsp_valid), '0);
      @(posedge clk); #1;
      if (!gap) begin
        sum  += $countones(bq[w][0]);
        done  = (bq[w].size() == 1);
        void'(bq[w].pop_front());
        beats++;
      end
      if (!done && beats == abort_after) begin
        rst = 1'b1;
        #1;
        check_outputs_zero("midburst_reset");
        bq[w] = saved;
        ptr   = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        apply_inputs(-1, 1'b0);
        return;
      end
    end
    pend[w] = 1'b0;

    for (int h = 0; h <= hold; h++) begin
      rsp_ready = (h == hold);
      apply_inputs(-1, 1'b0);
      @(negedge clk);
      check("rsp_valid", 64'(rsp_valid), 64'd1);
      check("rsp_id", 64'(rsp_id), 64'(w));
      check("rsp_count", 64'(rsp_count), 64'(sum));
      check("rsp_count_small", 64'(rsp_count_s), 64'(small_total(sum)));
      check("rsp_ready_bus", 64'(req_ready), '0);
      check("rsp_busy", 64'(busy), 64'd1);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b0;
    ptr = (w + 1) % N;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    rsp_ready = 1'b0;
    ptr       = 0;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;

    // Single-beat burst of all ones from requester 2.
    bq[2].push_back(32'hFFFF_FFFF); pend[2] = 1'b1;
    run_round(0, -1, 0);

    // Three-word burst from requester 0 while requester 1 waits.
    bq[0].push_back(32'h0000_000F);
    bq[0].push_back(32'h8000_0001);
    bq[0].push_back(32'h0000_0000);
    pend[0] = 1'b1;
    bq[1].push_back(32'h1234_5678); pend[1] = 1'b1;
    run_round(0, -1, 0);
    run_round(0, -1, 0);

    // Reset after two accepted words of a four-word burst from requester 3.
    for (int k = 0; k < 4; k++) bq[3].push_back($urandom);
    pend[3] = 1'b1;
    run_round(0, 2, 0);

    // Everyone requesting after reset: order 0,1,2,3,0.
    for (int i = 0; i < 3; i++) begin
      bq[i].push_back($urandom);
      pend[i] = 1'b1;
    end
    run_round(0, -1, 0);
    bq[0].push_back($urandom); pend[0] = 1'b1;
    repeat (4) run_round(0, -1, 0);

    // Response held for five cycles.
    bq[1].push_back(32'hA5A5_A5A5); pend[1] = 1'b1;
    run_round(5, -1, 0);

    // 96 ones: overflows the 6-bit instance.
    repeat (3) bq[2].push_back(32'hFFFF_FFFF);
    pend[2] = 1'b1;
    run_round(0, -1, 0);

    // Random traffic with gaps and response back-pressure.
    for (int r = 0; r < 150; r++) begin
      refill();
      run_round($urandom_range(0, 3), -1, 30);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/popcnt_arbiter.md
# popcnt_arbiter

Round-robin arbiter and sequencer that shares one 32-bit population-count datapath (count4 compressors feeding an RCA adder tree, 6-bit result 0..32) among NREQ requesters. Each requester owns the datapath for a burst of 32-bit words, delimited by a last flag. The block accumulates the per-word popcounts of that burst and returns one total per burst on a response channel tagged with the requester index. It sits between the bit-statistics clients and the shared popcount unit.

## Interface
- NREQ, 4: number of requesters, 2..8.
- ACC_W, 16: accumulator and response width, at least 6.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NREQ  per-requester word valid.
- req_data  input  32*NREQ  word i at bits [32*i+31:32*i].
- req_last  input  NREQ  marks the final word of requester i's burst.
- req_ready  output  NREQ  word accept; at most one bit high.
- rsp_valid  output  1  burst total available.
- rsp_id  output  clog2(NREQ)  requester that owned the burst.
- rsp_count  output  ACC_W  sum of popcounts over the burst.
- rsp_ready  input  1  response consumer accept.
- busy  output  1  high in GRANT and RESP.

## Operation
- FSM has three states: IDLE, GRANT, RESP.
- Reset values: state=IDLE, rr_ptr=0, owner=0, acc=0. Outputs: req_ready=0, rsp_valid=0, rsp_id=0, rsp_count=0, busy=0.
- IDLE: if any req_valid is high, pick the first set bit searching upward from rr_ptr (with wrap), register it as owner, clear acc, and go to GRANT. Otherwise stay in IDLE.
- GRANT: req_ready[owner]=1; all other req_ready bits are 0.
  - A word is accepted when req_valid[owner] and req_ready[owner] are both high.
  - On acceptance, acc <= acc + popcount(word).
  - If req_last is high on the accepted word, go to RESP.
  - Gaps with req_valid[owner]=0 are allowed; ownership is held.
- RESP: rsp_valid=1, rsp_id=owner, rsp_count=acc. Both are stable until rsp_ready. On rsp_ready, rr_ptr <= owner+1 (mod NREQ) and go to IDLE.
- Words from non-owners are never accepted. Their req_valid stays pending without loss.
- Requester i must not change its req_data or req_last while req_valid[i]=1 and the word is not yet accepted.
- Arithmetic: the popcount is zero-extended to ACC_W. Overflow handling is set by configuration.
- Reset mid-burst: the partial acc is discarded and no response is issued. The requester must restart its burst from its first word.

## Timing
- Arbitration: req_valid seen in IDLE at cycle 0 puts req_ready[owner] high in cycle 1.
- Single-beat burst: word accepted at the end of cycle 1, rsp_valid high in cycle 2.
- Throughput in GRANT: one word per cycle. The popcount is combinational within the cycle.
- Minimum turnaround between bursts: with rsp_ready held high, RESP lasts 1 cycle and IDLE lasts 1 cycle. A new grant appears 2 cycles after rsp_valid rises.
- rsp_valid and rsp_count are registered. req_ready is decoded from state and owner registers only, with no combinational path from req_valid.
- Simultaneous requests resolve in one cycle using rr_ptr. A winner that just finished has the lowest priority next round.

## Configuration
- POPCNT_SAT_EN defined: acc saturates at 2^ACC_W-1. Further words leave it pinned at that value.
- POPCNT_SAT_EN undefined: acc wraps modulo 2^ACC_W.

## Test plan
- Reset, then requester 2 sends one word 0xFFFFFFFF with last=1. Expect req_ready=0b0100 in cycle 1, then rsp_valid in cycle 2 with rsp_id=2, rsp_count=32.
- Requester 0 sends a 3-word burst 0x0000000F, 0x80000001, 0x00000000 (last on the third word). Expect rsp_count=6, rsp_id=0. Requester 1's concurrent valid is stalled with req_ready[1]=0 throughout.
- All four requesters hold valid with single-beat bursts and rsp_ready=1. Expect grant order 0,1,2,3,0. Response id order must match.
- Hold rsp_ready=0 for 5 cycles in RESP. Expect rsp_valid, rsp_id and rsp_count held constant and req_ready all 0.
- ACC_W=6 with a burst of three 0xFFFFFFFF words. Expect rsp_count=63 with POPCNT_SAT_EN defined, and 32 (96 mod 64) without it.
- Assert rst in GRANT after 2 accepted words. Expect all outputs zero immediately. The next burst from the same requester starts from acc=0 and is granted from rr_ptr=0.
